// File: rtl/parking_pkg.sv
// parking_pkg: shared lane state encoding and time-of-day widths/limits.
package parking_pkg;
  typedef enum logic [2:0] {IDLE, CHECK, OPEN, DENY, CLEAR} lane_state_e;
  localparam int HOUR_W = 5;
  localparam int MIN_W = 6;
  localparam int HOURS_PER_DAY = 24;
  localparam int MINS_PER_HOUR = 60;
endpackage

// File: rtl/gate_lane.sv
// gate_lane: debounced req/pass sensors, barrier FSM with timeout and class latch.
module gate_lane
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 4,
  parameter int OPEN_TIMEOUT = 64,
  parameter bit CHECK_EN = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  input  logic is_uni_i,
  input  logic pass_i,
  input  logic uni_space_i,
  input  logic guest_space_i,
  output logic gate_open_o,
  output logic denied_o,
  output logic evt_o,
  output logic evt_uni_o
);
  localparam int DW = $clog2(DEBOUNCE_CYC);
  localparam int TW = $clog2(OPEN_TIMEOUT);
  logic [1:0] raw, filt_q, rise_q;
  logic [1:0][DW-1:0] cnt_q;
  lane_state_e state_q, state_d;
  logic cls_q, cls_d, evt_q, evt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  assign raw = {pass_i, req_i};
  // bit 0 = req, bit 1 = pass; rise_q strobes for one cycle when a filter goes high
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      filt_q <= '0;
      rise_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        rise_q[i] <= 1'b0;
        if (raw[i] == filt_q[i]) cnt_q[i] <= '0;
        else if (cnt_q[i] == DW'(DEBOUNCE_CYC - 1)) begin
          filt_q[i] <= raw[i];
          rise_q[i] <= raw[i];
          cnt_q[i] <= '0;
        end else cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cls_q <= 1'b0;
      evt_q <= 1'b0;
      tmr_q <= '0;
    end else begin
      state_q <= state_d;
      cls_q <= cls_d;
      evt_q <= evt_d;
      tmr_q <= tmr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cls_d = cls_q;
    evt_d = 1'b0;
    tmr_d = '0;
    case (state_q)
      IDLE: if (rise_q[0]) begin
        state_d = CHECK;
        cls_d = is_uni_i;
      end
      CHECK: state_d = (!CHECK_EN || (cls_q ? uni_space_i : guest_space_i)) ? OPEN : DENY;
      OPEN: if (rise_q[1]) begin
        state_d = CLEAR;
        evt_d = 1'b1;
      end else if (tmr_q == TW'(OPEN_TIMEOUT - 1)) state_d = CLEAR;
      else tmr_d = tmr_q + 1'b1;
      DENY: if (!filt_q[0]) state_d = IDLE;
      CLEAR: if (filt_q == 2'b00) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign gate_open_o = state_q == OPEN;
  assign denied_o = state_q == DENY;
  assign evt_o = evt_q;
  assign evt_uni_o = evt_q & cls_q;
endmodule

// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl: entry/exit barrier lanes plus the minute/hour time-of-day counter.
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 4,
  parameter int OPEN_TIMEOUT = 64,
  parameter int HOUR_RESET = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic min_tick,
  input  logic ent_req,
  input  logic ent_is_uni,
  input  logic ent_pass,
  input  logic ext_req,
  input  logic ext_is_uni,
  input  logic ext_pass,
  input  logic uni_is_vacated_space,
  input  logic is_vacated_space,
  output logic car_entered,
  output logic is_uni_car_entered,
  output logic car_exited,
  output logic is_uni_car_exited,
  output logic ent_gate_open,
  output logic ext_gate_open,
  output logic ent_denied,
  output logic [HOUR_W-1:0] hour,
  output logic [MIN_W-1:0] minute
);
  logic ent_den, ext_den;
  logic [MIN_W-1:0] min_q, min_d;
  logic [HOUR_W-1:0] hour_q, hour_d;
  logic min_wrap;
  gate_lane #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .OPEN_TIMEOUT(OPEN_TIMEOUT), .CHECK_EN(1'b1)) u_ent (
    .clk(clk), .rst_n(rst_n), .req_i(ent_req), .is_uni_i(ent_is_uni), .pass_i(ent_pass),
    .uni_space_i(uni_is_vacated_space), .guest_space_i(is_vacated_space),
    .gate_open_o(ent_gate_open), .denied_o(ent_den), .evt_o(car_entered), .evt_uni_o(is_uni_car_entered)
  );
  gate_lane #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .OPEN_TIMEOUT(OPEN_TIMEOUT), .CHECK_EN(1'b0)) u_ext (
    .clk(clk), .rst_n(rst_n), .req_i(ext_req), .is_uni_i(ext_is_uni), .pass_i(ext_pass),
    .uni_space_i(uni_is_vacated_space), .guest_space_i(is_vacated_space),
    .gate_open_o(ext_gate_open), .denied_o(ext_den), .evt_o(car_exited), .evt_uni_o(is_uni_car_exited)
  );
  // the exit lane never reaches DENY, so its flag is constantly 0
  assign ent_denied = ent_den | ext_den;
  assign min_wrap = min_q == MIN_W'(MINS_PER_HOUR - 1);
  always_comb begin
    min_d = min_q;
    hour_d = hour_q;
    if (min_tick) begin
      min_d = min_wrap ? '0 : min_q + 1'b1;
      if (min_wrap) hour_d = (hour_q == HOUR_W'(HOURS_PER_DAY - 1)) ? '0 : hour_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      min_q <= '0;
      hour_q <= HOUR_W'(HOUR_RESET);
    end else begin
      min_q <= min_d;
      hour_q <= hour_d;
    end
  end
  assign hour = hour_q;
  assign minute = min_q;
endmodule

// File: tb/tb_parking_gate_ctrl.sv
// tb_parking_gate_ctrl: directed table-driven and sequence checks of parking_gate_ctrl.
module tb_parking_gate_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic min_tick = 1'b0;
  logic ent_req = 1'b0, ent_is_uni = 1'b0, ent_pass = 1'b0;
  logic ext_req = 1'b0, ext_is_uni = 1'b0, ext_pass = 1'b0;
  logic uni_is_vacated_space = 1'b0, is_vacated_space = 1'b0;
  logic car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
  logic ent_gate_open, ext_gate_open, ent_denied;
  logic [4:0] hour;
  logic [5:0] minute;
  int checks = 0;
  int failures = 0;

  typedef struct {
    logic uni;
    logic us;
    logic gs;
    logic open;
  } vec_t;
  vec_t tbl[6];

  parking_gate_ctrl dut (
    .clk(clk), .rst_n(rst_n), .min_tick(min_tick),
    .ent_req(ent_req), .ent_is_uni(ent_is_uni), .ent_pass(ent_pass),
    .ext_req(ext_req), .ext_is_uni(ext_is_uni), .ext_pass(ext_pass),
    .uni_is_vacated_space(uni_is_vacated_space), .is_vacated_space(is_vacated_space),
    .car_entered(car_entered), .is_uni_car_entered(is_uni_car_entered),
    .car_exited(car_exited), .is_uni_car_exited(is_uni_car_exited),
    .ent_gate_open(ent_gate_open), .ext_gate_open(ext_gate_open),
    .ent_denied(ent_denied), .hour(hour), .minute(minute)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    tbl[0] = '{uni: 1'b0, us: 1'b0, gs: 1'b1, open: 1'b1};
    tbl[1] = '{uni: 1'b0, us: 1'b1, gs: 1'b0, open: 1'b0};
    tbl[2] = '{uni: 1'b1, us: 1'b1, gs: 1'b0, open: 1'b1};
    tbl[3] = '{uni: 1'b1, us: 1'b0, gs: 1'b1, open: 1'b0};
    tbl[4] = '{uni: 1'b1, us: 1'b1, gs: 1'b1, open: 1'b1};
    tbl[5] = '{uni: 1'b0, us: 1'b0, gs: 1'b0, open: 1'b0};

    // reset
    tick(3);
    chk("rst_hour", hour, 8);
    chk("rst_minute", minute, 0);
    chk("rst_outs", {car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
                     ent_gate_open, ext_gate_open, ent_denied}, 0);
    rst_n = 1'b1;
    tick(2);
    chk("post_rst_outs", {car_entered, car_exited, ent_gate_open, ext_gate_open, ent_denied}, 0);

    // entry table: class x capacity flags
    for (int i = 0; i < 6; i++) begin
      uni_is_vacated_space = tbl[i].us;
      is_vacated_space = tbl[i].gs;
      ent_is_uni = tbl[i].uni;
      ent_req = 1'b1;
      tick(5);
      chk("pre_grant", {ent_gate_open, ent_denied}, 0);
      tick(1);
      chk("grant", {ent_gate_open, ent_denied}, {tbl[i].open, !tbl[i].open});
      if (tbl[i].open) begin
        ent_pass = 1'b1;
        tick(4);
        chk("pre_evt", {car_entered, ent_gate_open}, 2'b01);
        tick(1);
        chk("evt", {car_entered, is_uni_car_entered, ent_gate_open}, {1'b1, tbl[i].uni, 1'b0});
        tick(1);
        chk("evt_end", {car_entered, is_uni_car_entered, ent_gate_open}, 0);
      end else begin
        ent_req = 1'b0;
        tick(4);
        chk("deny_hold", {ent_denied, ent_gate_open, car_entered}, 3'b100);
        tick(1);
        chk("deny_drop", {ent_denied, ent_gate_open, car_entered}, 0);
      end
      ent_req = 1'b0;
      ent_pass = 1'b0;
      tick(8);
    end

    // pass with no grant is ignored
    ent_pass = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("nogrant_pass", {car_entered, ent_gate_open}, 0);
    end
    ent_pass = 1'b0;
    tick(8);

    // 3-cycle exit glitch
    ext_req = 1'b1;
    tick(3);
    ext_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("glitch", {ext_gate_open, car_exited}, 0);
    end

    // exit timeout
    ext_is_uni = 1'b1;
    ext_req = 1'b1;
    tick(5);
    chk("ext_pre_open", ext_gate_open, 0);
    for (int i = 0; i < 64; i++) begin
      tick(1);
      chk("ext_open_hold", {ext_gate_open, car_exited}, 2'b10);
    end
    tick(1);
    chk("ext_timeout", {ext_gate_open, car_exited}, 0);
    ext_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("ext_after_to", {ext_gate_open, car_exited}, 0);
    end

    // simultaneous guest entry + uni exit
    is_vacated_space = 1'b1;
    uni_is_vacated_space = 1'b0;
    ent_is_uni = 1'b0;
    ext_is_uni = 1'b1;
    ent_req = 1'b1;
    ext_req = 1'b1;
    tick(6);
    chk("both_open", {ent_gate_open, ext_gate_open}, 2'b11);
    ent_pass = 1'b1;
    ext_pass = 1'b1;
    tick(5);
    chk("both_evt", {car_entered, is_uni_car_entered, car_exited, is_uni_car_exited}, 4'b1011);
    tick(1);
    chk("both_evt_end", {car_entered, car_exited, ent_gate_open, ext_gate_open}, 0);
    ent_req = 1'b0; ext_req = 1'b0; ent_pass = 1'b0; ext_pass = 1'b0;
    tick(8);

    // reset while entry OPEN with a pass in flight
    ent_req = 1'b1;
    tick(6);
    chk("rst_open_pre", ent_gate_open, 1);
    ent_pass = 1'b1;
    tick(2);
    rst_n = 1'b0;
    ent_req = 1'b0;
    ent_pass = 1'b0;
    tick(1);
    chk("rst_open_gate", {ent_gate_open, car_entered}, 0);
    tick(1);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk("rst_open_nopulse", {car_entered, ent_gate_open}, 0);
    end

    // 960 minute ticks from reset: 08:00 -> 00:00
    min_tick = 1'b1;
    tick(1);
    chk("clk_1", {hour, minute}, {5'd8, 6'd1});
    tick(59);
    chk("clk_60", {hour, minute}, {5'd9, 6'd0});
    tick(899);
    chk("clk_959", {hour, minute}, {5'd23, 6'd59});
    tick(1);
    min_tick = 1'b0;
    chk("clk_wrap", {hour, minute}, {5'd0, 6'd0});
    tick(2);
    chk("clk_hold", {hour, minute}, {5'd0, 6'd0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
